pipe_stage_fifo: RTL and testbench

//  Parametrised pipeline stage buffer for the backend (exu->mem, mem->wb). Carries an opaque

---
 rtl/pipe_stage_fifo.sv | 76 +++++++
 tb/tb_pipe_stage_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// Pipeline stage buffer: DEPTH-entry FIFO with valid/ready handshake, synchronous flush,
// occupancy status and a saturating backpressure-cycle counter.
module pipe_stage_fifo #(
  parameter int DATA_WIDTH  = 256,
  parameter int DEPTH       = 2,
  parameter int STALL_CNT_W = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [STALL_CNT_W-1:0]       stall_cycles
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [STALL_CNT_W-1:0] stall;
  logic                  push, pop, stall_now;

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full         = (cnt == CNT_W'(DEPTH));
  assign empty        = (cnt == '0);
  assign in_ready     = ~full;
  assign out_valid    = ~empty;
  assign out_data     = empty ? '0 : mem[rd_ptr];
  assign count        = cnt;
  assign stall_cycles = stall;

  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign stall_now = in_valid & ~in_ready & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Flush leaves the perf counter alone; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 stall <= '0;
    else if (stall_now && !(&stall)) stall <= stall + STALL_CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: two instances (DEPTH=2/32-bit counter, DEPTH=3/4-bit counter)
// share stimulus; each is checked against a queue model and a scoreboard at the falling edge.
module tb_pipe_stage_fifo;

  logic       clock = 1'b0;
  logic       reset_n, flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic       ir0, ov0, fu0, em0, ir1, ov1, fu1, em1;
  logic [7:0] od0, od1;
  logic [1:0] cn0, cn1;
  logic [31:0] sc0;
  logic [3:0]  sc1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mq [2][$];
  logic [31:0] sm [2];

  always #5 clock = ~clock;

  pipe_stage_fifo #(.DATA_WIDTH(8), .DEPTH(2), .STALL_CNT_W(32)) u0 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .count(cn0), .full(fu0), .empty(em0), .stall_cycles(sc0));

  pipe_stage_fifo #(.DATA_WIDTH(8), .DEPTH(3), .STALL_CNT_W(4)) u1 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .count(cn1), .full(fu1), .empty(em1), .stall_cycles(sc1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compare state against the model, then advance the model
  // with the inputs that will be sampled at the next rising edge.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic        ovi, fui, emi, iri;
      logic [7:0]  odi;
      logic [1:0]  cni;
      logic [31:0] sci, smax, expd;
      int          dep, sz;
      ovi  = i ? ov1 : ov0;  fui = i ? fu1 : fu0;  emi = i ? em1 : em0;
      iri  = i ? ir1 : ir0;  odi = i ? od1 : od0;  cni = i ? cn1 : cn0;
      sci  = i ? {28'b0, sc1} : sc0;
      dep  = i ? 3 : 2;
      smax = i ? 32'hF : 32'hFFFF_FFFF;
      if (!reset_n) begin
        mq[i].delete();
        sm[i] = 0;
        chk($sformatf("rst_out_valid[%0d]", i), {31'b0, ovi}, 0);
        chk($sformatf("rst_count[%0d]", i), {30'b0, cni}, 0);
        chk($sformatf("rst_in_ready[%0d]", i), {31'b0, iri}, 1);
        chk($sformatf("rst_flags[%0d]", i), {30'b0, fui, emi}, 32'b01);
        chk($sformatf("rst_stall[%0d]", i), sci, 0);
        chk($sformatf("rst_out_data[%0d]", i), {24'b0, odi}, 0);
      end else begin
        sz   = mq[i].size();
        expd = (sz > 0) ? {24'b0, mq[i][0]} : 32'h0;
        chk($sformatf("count[%0d]", i), {30'b0, cni}, sz);
        chk($sformatf("full_empty[%0d]", i), {30'b0, fui, emi}, {30'b0, sz == dep, sz == 0});
        chk($sformatf("in_ready[%0d]", i), {31'b0, iri}, {31'b0, sz < dep});
        chk($sformatf("out_valid[%0d]", i), {31'b0, ovi}, {31'b0, sz > 0});
        chk($sformatf("out_data[%0d]", i), {24'b0, odi}, expd);
        chk($sformatf("stall[%0d]", i), sci, sm[i]);
        if (flush) begin
          mq[i].delete();
        end else begin
          if (in_valid && sz == dep && sm[i] != smax) sm[i]++;
          if (sz > 0 && out_ready) void'(mq[i].pop_front());
          if (in_valid && sz < dep) mq[i].push_back(in_data);
        end
      end
    end
  end

  // Drive inputs for one cycle; returns 2 time units after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(posedge clock); #2;
  endtask

  initial begin
    logic [31:0] s0;
    int          k, guard;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    cyc(0, 8'h00, 0, 0);

    // Fill and backpressure
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    chk("fill_full", {31'b0, fu0}, 1);
    chk("fill_head", {24'b0, od0}, 32'h11);
    repeat (3) cyc(1, 8'h33, 0, 0);
    chk("stall_3", sc0, 3);
    repeat (2) cyc(1, 8'h33, 1, 0);
    repeat (4) cyc(0, 8'h00, 1, 0);

    // Simultaneous push/pop at count=1
    cyc(1, 8'h44, 0, 0);
    cyc(1, 8'h55, 1, 0);
    chk("pushpop_count", {30'b0, cn0}, 1);
    chk("pushpop_data", {24'b0, od0}, 32'h55);
    repeat (3) cyc(0, 8'h00, 1, 0);

    // Flush with a full buffer and a beat offered
    cyc(1, 8'h61, 0, 0);
    cyc(1, 8'h62, 0, 0);
    s0 = sc0;
    cyc(1, 8'h66, 1, 1);
    chk("flush_empty", {31'b0, em0}, 1);
    chk("flush_count", {30'b0, cn0}, 0);
    chk("flush_stall", sc0, s0);
    cyc(0, 8'h00, 1, 0);

    // Wrap on DEPTH=3: stream 1..7 with out_ready toggling
    k = 1; guard = 0;
    while (k <= 7 && guard < 60) begin
      logic acc;
      acc = ir1;
      cyc(1, 8'(k), guard[0] == 1'b0, 0);
      if (acc) k++;
      guard++;
    end
    chk("wrap_guard", {31'b0, guard >= 60}, 0);
    repeat (6) cyc(0, 8'h00, 1, 0);

    // Saturation of the 4-bit counter
    repeat (20) cyc(1, 8'($urandom), 0, 0);
    chk("sat_0xF", {28'b0, sc1}, 32'hF);
    repeat (3) cyc(1, 8'h77, 0, 0);
    chk("sat_hold", {28'b0, sc1}, 32'hF);
    repeat (4) cyc(0, 8'h00, 1, 0);

    // Reset mid-stream with count=2
    cyc(1, 8'h81, 0, 0);
    cyc(1, 8'h82, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("rst_now_valid", {31'b0, ov0}, 0);
    chk("rst_now_count", {30'b0, cn0}, 0);
    chk("rst_now_ready", {31'b0, ir0}, 1);
    chk("rst_now_stall", sc0, 0);
    in_valid = 1'b0;
    @(posedge clock); #2 reset_n = 1'b1;
    cyc(1, 8'hA5, 0, 0);
    chk("post_rst_data", {24'b0, od0}, 32'hA5);
    chk("post_rst_valid", {31'b0, ov0}, 1);

    // Random traffic
    repeat (400) cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                     $urandom_range(0, 19) == 0);
    repeat (6) cyc(0, 8'h00, 1, 0);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
